// File: rtl/reduce_pkg.sv
// Shared op encoding and padding helper for the pipelined N-way reduction unit.
package reduce_pkg;

    typedef logic [1:0] reduce_op_t;

    localparam reduce_op_t OP_OR  = 2'b00;
    localparam reduce_op_t OP_AND = 2'b01;
    localparam reduce_op_t OP_XOR = 2'b10;
    localparam reduce_op_t OP_NOR = 2'b11;

    // Value that leaves the reduction unchanged; NOR pads as OR since it is an inverted OR tree.
    function automatic logic identity_bit(input reduce_op_t op);
        return (op == OP_AND);
    endfunction

endpackage

// File: rtl/reduce_stage.sv
// One registered tree level: folds IN_W bits to IN_W/2 using the op carried with the word.
module reduce_stage
    import reduce_pkg::*;
#(
    parameter int IN_W = 2,
    parameter bit LAST = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    input  logic [IN_W-1:0]   in_data,
    input  reduce_op_t        in_op,
    input  logic              in_valid,
    output logic [IN_W/2-1:0] out_data,
    output reduce_op_t        out_op,
    output logic              out_valid
);

    localparam int OUT_W = IN_W / 2;

    logic [OUT_W-1:0] folded;

    always_comb begin
        folded = '0;
        for (int i = 0; i < OUT_W; i++) begin
            case (in_op)
                OP_AND:  folded[i] = in_data[2*i] & in_data[2*i+1];
                OP_XOR:  folded[i] = in_data[2*i] ^ in_data[2*i+1];
                default: folded[i] = in_data[2*i] | in_data[2*i+1];
            endcase
        end
        // NOR runs as an OR tree all the way down and flips only at the root.
        if (LAST && (in_op == OP_NOR)) begin
            folded = ~folded;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_op    <= OP_OR;
            out_valid <= 1'b0;
        end else if (advance) begin
            out_data  <= folded;
            out_op    <= in_op;
            out_valid <= in_valid;
        end
    end

endmodule

// File: rtl/reduce_nway_pipe.sv
// Pipelined WIDTH-input OR/AND/XOR/NOR reduction with valid/ready backpressure.
// Optional sticky result accumulator is built when STICKY_ACC_EN is defined.
module reduce_nway_pipe
    import reduce_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  reduce_op_t       in_op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_data,
    output reduce_op_t       out_op,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             acc_clear,
    output logic             acc_out
);

    localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PAD_W  = 1 << LEVELS;
    localparam int TREE_W = 2 * PAD_W - 1;

    // All levels packed in one vector: level j starts at bit 2*PAD_W - 2*(PAD_W >> j).
    logic [TREE_W-1:0] tree_data;
    reduce_op_t        lvl_op [0:LEVELS];
    logic [LEVELS:0]   lvl_valid;
    logic [PAD_W-1:0]  padded;
    logic              advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    always_comb begin
        padded = {PAD_W{identity_bit(in_op)}};
        padded[WIDTH-1:0] = in_data;
    end

    assign tree_data[PAD_W-1:0] = padded;
    assign lvl_op[0]            = in_op;
    assign lvl_valid[0]         = in_valid;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        localparam int IN_W    = PAD_W >> (k - 1);
        localparam int IN_OFF  = 2 * PAD_W - 2 * IN_W;
        localparam int OUT_OFF = 2 * PAD_W - IN_W;

        reduce_stage #(
            .IN_W (IN_W),
            .LAST (k == LEVELS)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .advance   (advance),
            .in_data   (tree_data[IN_OFF +: IN_W]),
            .in_op     (lvl_op[k-1]),
            .in_valid  (lvl_valid[k-1]),
            .out_data  (tree_data[OUT_OFF +: IN_W/2]),
            .out_op    (lvl_op[k]),
            .out_valid (lvl_valid[k])
        );
    end

    assign out_data  = tree_data[TREE_W-1];
    assign out_op    = lvl_op[LEVELS];
    assign out_valid = lvl_valid[LEVELS];

`ifdef STICKY_ACC_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_out <= 1'b0;
        end else if (acc_clear) begin
            acc_out <= 1'b0;
        end else if (out_valid && out_ready) begin
            acc_out <= acc_out | out_data;
        end
    end
`else
    logic unused_acc_clear;
    assign unused_acc_clear = acc_clear;
    assign acc_out          = 1'b0;
`endif

endmodule

// File: tb/tb_reduce_nway_pipe.sv
// Bench for reduce_nway_pipe: WIDTH=8 and WIDTH=5 instances share one stimulus stream
// and are compared every cycle against a queue-based model of the reduction pipeline.
module tb_reduce_nway_pipe;
    import reduce_pkg::*;

    localparam int LEVELS = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = '0;
    logic [4:0] in_data5;
    reduce_op_t in_op = OP_OR;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       acc_clear = 1'b0;

    logic in_ready8, out_data8, out_valid8, acc8;
    logic in_ready5, out_data5, out_valid5, acc5;
    reduce_op_t out_op8, out_op5;

    assign in_data5 = in_data[4:0];

    always #5 clk = ~clk;

    reduce_nway_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_op(in_op), .in_valid(in_valid),
        .in_ready(in_ready8), .out_data(out_data8), .out_op(out_op8), .out_valid(out_valid8),
        .out_ready(out_ready), .acc_clear(acc_clear), .acc_out(acc8)
    );

    reduce_nway_pipe #(.WIDTH(5)) dut5 (
        .clk(clk), .reset(reset), .in_data(in_data5), .in_op(in_op), .in_valid(in_valid),
        .in_ready(in_ready5), .out_data(out_data5), .out_op(out_op5), .out_valid(out_valid5),
        .out_ready(out_ready), .acc_clear(acc_clear), .acc_out(acc5)
    );

    typedef struct {
        logic       r8;
        logic       r5;
        logic [1:0] op;
        int         tag;
    } exp_t;

    exp_t       q[$];
    logic [2:0] got8[$];
    logic [2:0] got5[$];
    int         total = 0;
    int         bad = 0;
    int         adv_total = 0;
    logic       acc_m8 = 1'b0;
    logic       acc_m5 = 1'b0;

    function automatic logic model(input logic [7:0] d, input int w, input logic [1:0] op);
        logic [7:0] m;
        m = 8'((1 << w) - 1);
        case (op)
            2'd0:    return |(d & m);
            2'd1:    return &(d | ~m);
            2'd2:    return ^(d & m);
            default: return !(|(d & m));
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Present a word and hold it until accepted; leaves in_valid asserted for back-to-back use.
    task automatic send(input logic [7:0] d, input reduce_op_t o);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_op    = o;
        #1;
        n = 0;
        while (!in_ready8 && n < 50) begin
            cycle();
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'(in_ready8), 1);
        cycle();
    endtask

    task automatic wait_out(output int n);
        n = 1;
        while (!out_valid8 && n < 20) begin
            cycle();
            n++;
        end
    endtask

    // Model: a word accepted on an advancing edge reaches the output after LEVELS advances.
    always @(negedge clk) begin
        logic exp_v;
        if (reset) begin
            q.delete();
            acc_m8 = 1'b0;
            acc_m5 = 1'b0;
        end else begin
            exp_v = (q.size() > 0) && (adv_total - q[0].tag + 1 == LEVELS);
            chk("out_valid8", 32'(out_valid8), 32'(exp_v));
            chk("out_valid5", 32'(out_valid5), 32'(exp_v));
            chk("in_ready8", 32'(in_ready8), 32'(!exp_v || out_ready));
            chk("in_ready5", 32'(in_ready5), 32'(!exp_v || out_ready));
            if (exp_v) begin
                chk("out_data8", 32'(out_data8), 32'(q[0].r8));
                chk("out_data5", 32'(out_data5), 32'(q[0].r5));
                chk("out_op8", 32'(out_op8), 32'(q[0].op));
                chk("out_op5", 32'(out_op5), 32'(q[0].op));
            end
            if (out_valid8 && out_ready) got8.push_back({out_op8, out_data8});
            if (out_valid5 && out_ready) got5.push_back({out_op5, out_data5});
            chk("acc_out8", 32'(acc8), 32'(acc_m8));
            chk("acc_out5", 32'(acc5), 32'(acc_m5));
`ifdef STICKY_ACC_EN
            if (acc_clear) begin
                acc_m8 = 1'b0;
                acc_m5 = 1'b0;
            end else if (exp_v && out_ready) begin
                acc_m8 = acc_m8 | q[0].r8;
                acc_m5 = acc_m5 | q[0].r5;
            end
`endif
            if (exp_v && out_ready) void'(q.pop_front());
            if (!exp_v || out_ready) begin
                adv_total++;
                if (in_valid)
                    q.push_back('{r8: model(in_data, 8, in_op), r5: model(in_data, 5, in_op),
                                  op: in_op, tag: adv_total});
            end
        end
    end

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_out_valid8", 32'(out_valid8), 0);
        chk("rst_out_valid5", 32'(out_valid5), 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_in_ready8", 32'(in_ready8), 1);
        chk("rst_in_ready5", 32'(in_ready5), 1);
    endtask

    logic [7:0] bp_words [0:5];
    logic [2:0] bp_exp [0:5];

    initial begin
        int n;
        int sent;
        logic took;
        logic held;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 32'(out_valid8), 0);
        reset = 1'b0;
        #1;
        chk("reset_in_ready", 32'(in_ready8), 1);
        chk("reset_out_data", 32'(out_data8), 0);
        chk("reset_out_op", 32'(out_op8), 0);
        chk("reset_acc", 32'(acc8), 0);
        cycle();

        // OR latency
        got8.delete();
        send(8'h00, OP_OR);
        in_valid = 1'b0;
        wait_out(n);
        chk("latency_first", n, 3);
        send(8'h10, OP_OR);
        in_valid = 1'b0;
        wait_out(n);
        chk("latency_second", n, 3);
        repeat (4) cycle();
        chk("or_count", got8.size(), 2);
        if (got8.size() == 2) begin
            chk("or_res0", 32'(got8[0]), 32'(3'b000));
            chk("or_res1", 32'(got8[1]), 32'(3'b001));
        end

        // mixed ops back to back
        got8.delete();
        send(8'hFF, OP_AND);
        send(8'hFE, OP_AND);
        send(8'h07, OP_XOR);
        send(8'h00, OP_NOR);
        in_valid = 1'b0;
        repeat (6) cycle();
        chk("mix_count", got8.size(), 4);
        if (got8.size() == 4) begin
            chk("mix_res0", 32'(got8[0]), 32'(3'b011));
            chk("mix_res1", 32'(got8[1]), 32'(3'b010));
            chk("mix_res2", 32'(got8[2]), 32'(3'b101));
            chk("mix_res3", 32'(got8[3]), 32'(3'b111));
        end

        // padding on the 5-bit instance
        got5.delete();
        send(8'h1F, OP_AND);
        send(8'h10, OP_OR);
        send(8'h03, OP_XOR);
        in_valid = 1'b0;
        repeat (6) cycle();
        chk("pad_count", got5.size(), 3);
        if (got5.size() == 3) begin
            chk("pad_and", 32'(got5[0]), 32'(3'b011));
            chk("pad_or", 32'(got5[1]), 32'(3'b001));
            chk("pad_xor", 32'(got5[2]), 32'(3'b100));
        end

        // backpressure: out_ready low for 4 cycles mid-stream
        bp_words = '{8'h01, 8'h00, 8'h80, 8'h00, 8'hFF, 8'h00};
        bp_exp   = '{3'b001, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000};
        got8.delete();
        sent = 0;
        held = 1'b0;
        for (int i = 0; i < 60; i++) begin
            out_ready = !(i >= 4 && i < 8);
            in_valid  = (sent < 6);
            in_data   = (sent < 6) ? bp_words[sent] : 8'h00;
            in_op     = OP_OR;
            #1;
            if (i == 4) held = out_data8;
            if (i >= 4 && i < 8) begin
                chk("stall_in_ready", 32'(in_ready8), 0);
                chk("stall_valid", 32'(out_valid8), 1);
                chk("stall_hold", 32'(out_data8), 32'(held));
            end
            took = in_valid && in_ready8;
            cycle();
            if (took) sent++;
            if (sent == 6 && i >= 8) break;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) cycle();
        chk("bp_count", got8.size(), 6);
        if (got8.size() == 6)
            for (int i = 0; i < 6; i++) chk("bp_order", 32'(got8[i]), 32'(bp_exp[i]));

        // async reset with words in flight
        out_ready = 1'b0;
        send(8'hFF, OP_OR);
        send(8'h00, OP_AND);
        in_valid = 1'b0;
        repeat (3) cycle();
        chk("inflight_valid", 32'(out_valid8), 1);
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("no_stale", 32'(out_valid8), 0);
        end

        // sticky accumulator
        acc_clear = 1'b1;
        cycle();
        acc_clear = 1'b0;
        send(8'h00, OP_OR);
        send(8'h00, OP_OR);
        send(8'h10, OP_OR);
        send(8'h00, OP_OR);
        in_valid = 1'b0;
        repeat (6) cycle();
`ifdef STICKY_ACC_EN
        chk("acc_sticky", 32'(acc8), 1);
`else
        chk("acc_tied", 32'(acc8), 0);
`endif
        send(8'h10, OP_OR);
        in_valid = 1'b0;
        wait_out(n);
        chk("acc_wait", 32'(out_valid8), 1);
        acc_clear = 1'b1;
        cycle();
        acc_clear = 1'b0;
        chk("acc_clear_prio", 32'(acc8), 0);
        repeat (4) cycle();

        // randomized traffic with a reset in the middle
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 1500; i++) begin
                in_valid  = ($urandom % 4) != 0;
                in_data   = 8'($urandom);
                in_op     = 2'($urandom);
                out_ready = ($urandom % 3) != 0;
                acc_clear = ($urandom % 20) == 0;
                cycle();
            end
            if (pass == 0) do_reset();
        end
        in_valid  = 1'b0;
        acc_clear = 1'b0;
        out_ready = 1'b1;
        repeat (8) cycle();
        chk("drain_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
